// File: rtl/segment_chase_ctrl_if.sv
// Control/display bundle of the segment-chase animator: button and mode inputs
// toward the controller, segment/anode/status outputs back from it.
interface segment_chase_ctrl_if #(
    parameter int NUM_SPEEDS = 4,
    parameter int NUM_DIGITS = 4
);
    localparam int SPEED_W = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
    localparam int DSEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  btn_up;
    logic                  btn_down;
    logic                  dir;
    logic                  pause;
    logic [DSEL_W-1:0]     dsel;
    logic [6:0]            disp;
    logic [NUM_DIGITS-1:0] anode;
    logic [SPEED_W-1:0]    speed;
    logic                  step;
    logic                  lap;

    modport master (
        output btn_up, btn_down, dir, pause, dsel,
        input  disp, anode, speed, step, lap
    );

    modport slave (
        input  btn_up, btn_down, dir, pause, dsel,
        output disp, anode, speed, step, lap
    );
endinterface

// File: rtl/segment_chase_ctrl.sv
// Segment-chase animator: one dark segment walks around the a..f ring of the
// selected digit at a button-adjustable rate derived from clock enables.
module segment_chase_ctrl #(
    parameter int BASE_DIV    = 50000,
    parameter int NUM_SPEEDS  = 4,
    parameter int RESET_SPEED = 0,
    parameter int DEB_CYCLES  = 250000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    segment_chase_ctrl_if.slave bus
);
    localparam int SPEED_W = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
    localparam int DSEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W   = $clog2(BASE_DIV << (NUM_SPEEDS - 1));
    localparam int CNT_W   = $clog2(DEB_CYCLES + 1);

    logic [1:0]              btn_raw_s;
    logic [1:0]              sync1_r;
    logic [1:0]              sync2_r;
    logic [1:0]              level_r;
    logic [1:0]              press_r;
    logic [1:0][CNT_W-1:0]   deb_cnt_r;
    logic [SPEED_W-1:0]      speed_r;
    logic [SPEED_W-1:0]      speed_nxt_s;
    logic                    spd_clr_s;
    logic [DIV_W-1:0]        div_r;
    logic [DIV_W-1:0]        div_nxt_s;
    logic [DIV_W-1:0]        div_last_s;
    logic                    tick_s;
    logic                    lap_nxt_s;
    logic [2:0]              pos_r;
    logic [2:0]              pos_nxt_s;
    logic [6:0]              disp_r;
    logic [NUM_DIGITS-1:0]   anode_r;
    logic                    step_r;
    logic                    lap_r;

    function automatic logic [6:0] seg_of(input logic [2:0] p);
        case (p)
            3'd0:    seg_of = 7'b0111111;
            3'd1:    seg_of = 7'b1011111;
            3'd2:    seg_of = 7'b1101111;
            3'd3:    seg_of = 7'b1110111;
            3'd4:    seg_of = 7'b1111011;
            3'd5:    seg_of = 7'b1111101;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    assign btn_raw_s = {bus.btn_down, bus.btn_up};

    // Synchronise both buttons and accept a new level after DEB_CYCLES equal samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r   <= 2'b00;
            sync2_r   <= 2'b00;
            level_r   <= 2'b00;
            press_r   <= 2'b00;
            deb_cnt_r <= '0;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            for (int b = 0; b < 2; b++) begin
                if (sync2_r[b] == level_r[b]) begin
                    deb_cnt_r[b] <= CNT_W'(0);
                    press_r[b]   <= 1'b0;
                end else if (deb_cnt_r[b] == CNT_W'(DEB_CYCLES - 1)) begin
                    deb_cnt_r[b] <= CNT_W'(0);
                    level_r[b]   <= sync2_r[b];
                    press_r[b]   <= sync2_r[b];
                end else begin
                    deb_cnt_r[b] <= deb_cnt_r[b] + CNT_W'(1);
                    press_r[b]   <= 1'b0;
                end
            end
        end
    end

    // Speed update; a lone press (even a saturated one) restarts the period
    always_comb begin
        speed_nxt_s = speed_r;
        spd_clr_s   = 1'b0;
        case (press_r)
            2'b01: begin
                spd_clr_s = 1'b1;
                if (speed_r != SPEED_W'(0)) speed_nxt_s = speed_r - SPEED_W'(1);
                else                        speed_nxt_s = speed_r;
            end
            2'b10: begin
                spd_clr_s = 1'b1;
                if (speed_r != SPEED_W'(NUM_SPEEDS - 1)) speed_nxt_s = speed_r + SPEED_W'(1);
                else                                     speed_nxt_s = speed_r;
            end
            default: begin
                speed_nxt_s = speed_r;
                spd_clr_s   = 1'b0;
            end
        endcase
    end

    // Period divider and ring position; dir is only looked at on the step itself
    always_comb begin
        div_last_s = DIV_W'((BASE_DIV << speed_r) - 1);
        tick_s     = !bus.pause && (div_r == div_last_s);
        div_nxt_s  = div_r;
        pos_nxt_s  = pos_r;
        lap_nxt_s  = 1'b0;
        if (spd_clr_s || tick_s) div_nxt_s = DIV_W'(0);
        else if (bus.pause)      div_nxt_s = div_r;
        else                     div_nxt_s = div_r + DIV_W'(1);
        if (tick_s) begin
            if (bus.dir) begin
                lap_nxt_s = (pos_r == 3'd0);
                pos_nxt_s = (pos_r == 3'd0) ? 3'd5 : pos_r - 3'd1;
            end else begin
                lap_nxt_s = (pos_r == 3'd5);
                pos_nxt_s = (pos_r == 3'd5) ? 3'd0 : pos_r + 3'd1;
            end
        end else begin
            pos_nxt_s = pos_r;
            lap_nxt_s = 1'b0;
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_r <= SPEED_W'(RESET_SPEED);
            div_r   <= DIV_W'(0);
            pos_r   <= 3'd0;
            disp_r  <= 7'b0111111;
            step_r  <= 1'b0;
            lap_r   <= 1'b0;
            anode_r <= ~{{(NUM_DIGITS-1){1'b0}}, 1'b1};
        end else begin
            speed_r <= speed_nxt_s;
            div_r   <= div_nxt_s;
            pos_r   <= pos_nxt_s;
            disp_r  <= seg_of(pos_nxt_s);
            step_r  <= tick_s;
            lap_r   <= lap_nxt_s;
            if ({1'b0, bus.dsel} < (DSEL_W + 1)'(NUM_DIGITS))
                anode_r <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << bus.dsel);
            else
                anode_r <= anode_r;
        end
    end

    assign bus.disp  = disp_r;
    assign bus.anode = anode_r;
    assign bus.speed = speed_r;
    assign bus.step  = step_r;
    assign bus.lap   = lap_r;
endmodule

// File: tb/tb_segment_chase_ctrl.sv
// Randomised scoreboard bench: a reference model predicts step events from the
// rules (run lengths, countdown periods, modular position) and a monitor checks them.
module tb_segment_chase_ctrl;
    localparam int BASE_DIV    = 4;
    localparam int NUM_SPEEDS  = 4;
    localparam int RESET_SPEED = 0;
    localparam int DEB_CYCLES  = 3;
    localparam int NUM_DIGITS  = 4;

    logic clk = 1'b0;
    logic reset;

    segment_chase_ctrl_if #(.NUM_SPEEDS(NUM_SPEEDS), .NUM_DIGITS(NUM_DIGITS)) bus ();

    segment_chase_ctrl #(
        .BASE_DIV(BASE_DIV), .NUM_SPEEDS(NUM_SPEEDS), .RESET_SPEED(RESET_SPEED),
        .DEB_CYCLES(DEB_CYCLES), .NUM_DIGITS(NUM_DIGITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [6:0] disp; logic lap; } step_t;
    step_t sq[$];
    step_t e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int   m_speed = RESET_SPEED;
    int   m_rem   = BASE_DIV << RESET_SPEED;
    int   m_pos   = 0;
    logic [NUM_DIGITS-1:0] m_anode = 4'b1110;
    int   run[2]    = '{0, 0};
    logic d1[2]     = '{1'b0, 1'b0};
    logic d2[2]     = '{1'b0, 1'b0};
    logic last_s[2] = '{1'b0, 1'b0};
    logic lvl[2]    = '{1'b0, 1'b0};
    logic prs[2]    = '{1'b0, 1'b0};
    logic up_now, dn_now, raw_v, samp_v, stepped, lap_v;

    function automatic logic [6:0] ring_disp(int p);
        logic [6:0] v;
        v = 7'b1111111;
        v[6-p] = 1'b0;
        return v;
    endfunction

    function automatic int period(int s);
        return BASE_DIV << s;
    endfunction

    // Reference model: countdown to next step, speed walk, debounced presses
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_speed = RESET_SPEED;
            m_rem   = period(RESET_SPEED);
            m_pos   = 0;
            m_anode = 4'b1110;
            for (int b = 0; b < 2; b++) begin
                run[b] = 0; d1[b] = 1'b0; d2[b] = 1'b0;
                last_s[b] = 1'b0; lvl[b] = 1'b0; prs[b] = 1'b0;
            end
            sq.delete();
        end else begin
            cyc++;
            up_now = prs[0];
            dn_now = prs[1];
            for (int b = 0; b < 2; b++) begin
                raw_v  = (b == 0) ? bus.btn_up : bus.btn_down;
                samp_v = d2[b];
                d2[b]  = d1[b];
                d1[b]  = raw_v;
                run[b] = (samp_v == last_s[b]) ? run[b] + 1 : 1;
                last_s[b] = samp_v;
                prs[b] = 1'b0;
                if (run[b] >= DEB_CYCLES && samp_v != lvl[b]) begin
                    lvl[b] = samp_v;
                    prs[b] = samp_v;
                end
            end
            stepped = 1'b0;
            if (!bus.pause) begin
                m_rem--;
                if (m_rem == 0) begin
                    stepped = 1'b1;
                    lap_v = bus.dir ? (m_pos == 0) : (m_pos == 5);
                    m_pos = bus.dir ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
                    sq.push_back('{cyc, ring_disp(m_pos), lap_v});
                end
            end
            if (up_now != dn_now) begin
                if (up_now) m_speed = (m_speed > 0) ? m_speed - 1 : 0;
                else        m_speed = (m_speed < NUM_SPEEDS - 1) ? m_speed + 1 : NUM_SPEEDS - 1;
                m_rem = period(m_speed);
            end else if (stepped) begin
                m_rem = period(m_speed);
            end
            if (bus.dsel < NUM_DIGITS) m_anode = ~(4'b0001 << bus.dsel);
        end
    end

    // Monitor: per-cycle status checks and step scoreboard
    always @(negedge clk) begin
        if (reset) begin
            total++;
            if (bus.speed !== 2'(m_speed)) begin
                bad++; $display("FAIL speed cyc=%0d got=%0d want=%0d", cyc, bus.speed, m_speed);
            end
            total++;
            if (bus.anode !== m_anode) begin
                bad++; $display("FAIL anode cyc=%0d got=%b want=%b", cyc, bus.anode, m_anode);
            end
            total++;
            if (bus.disp !== ring_disp(m_pos)) begin
                bad++; $display("FAIL disp cyc=%0d got=%b want=%b", cyc, bus.disp, ring_disp(m_pos));
            end
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                total++; bad++;
                $display("FAIL missing_step got=none want=step at cyc %0d", sq[0].cyc);
                void'(sq.pop_front());
            end
            if (bus.step === 1'b1) begin
                total++;
                if (sq.size() == 0) begin
                    bad++; $display("FAIL unexpected_step cyc=%0d got=step want=none", cyc);
                end else begin
                    e = sq.pop_front();
                    if (e.cyc != cyc || bus.disp !== e.disp || bus.lap !== e.lap) begin
                        bad++;
                        $display("FAIL step cyc got=%0d want=%0d disp got=%b want=%b lap got=%b want=%b",
                                 cyc, e.cyc, bus.disp, e.disp, bus.lap, e.lap);
                    end
                end
            end else begin
                total++;
                if (bus.lap !== 1'b0) begin
                    bad++; $display("FAIL lap_without_step cyc=%0d got=%b want=0", cyc, bus.lap);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic press(input bit up, input bit down, input int hold);
        bus.btn_up   = up;
        bus.btn_down = down;
        tick(hold);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(8);
    endtask

    initial begin
        int hu, hd;
        hu = 0;
        hd = 0;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.dir = 1'b0; bus.pause = 1'b0; bus.dsel = 2'd0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #10;
        check("rst_disp",  32'(bus.disp),  32'(7'b0111111));
        check("rst_anode", 32'(bus.anode), 32'(4'b1110));
        check("rst_speed", 32'(bus.speed), 32'd0);
        check("rst_step",  32'(bus.step),  32'd0);
        check("rst_lap",   32'(bus.lap),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(30);

        press(1'b0, 1'b1, 6);
        check("speed_after_down", 32'(bus.speed), 32'd1);
        tick(30);
        repeat (3) press(1'b0, 1'b1, 6);
        check("speed_three_more", 32'(bus.speed), 32'd3);
        press(1'b0, 1'b1, 6);
        check("speed_saturate_hi", 32'(bus.speed), 32'd3);
        tick(70);
        press(1'b1, 1'b0, 2);
        check("short_pulse_ignored", 32'(bus.speed), 32'd3);
        tick(70);
        repeat (4) press(1'b1, 1'b0, 6);
        check("speed_saturate_lo", 32'(bus.speed), 32'd0);

        for (int k = 0; k < 200 && bus.disp !== 7'b0111111; k++) tick(1);
        check("find_pos0", 32'(bus.disp), 32'(7'b0111111));
        bus.dir = 1'b1;
        tick(20);
        tick(1);
        bus.pause = 1'b1;
        tick(20);
        bus.pause = 1'b0;
        tick(20);
        press(1'b1, 1'b1, 6);
        check("both_pressed", 32'(bus.speed), 32'd0);
        tick(20);

        for (int i = 0; i < 4000; i++) begin
            if (hu == 0) begin bus.btn_up = ($urandom_range(0, 3) == 0); hu = $urandom_range(1, 10); end
            else hu--;
            if (hd == 0) begin bus.btn_down = ($urandom_range(0, 3) == 0); hd = $urandom_range(1, 10); end
            else hd--;
            if ($urandom_range(0, 39) == 0) bus.pause = ~bus.pause;
            if ($urandom_range(0, 59) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 7) == 0) bus.dsel = 2'($urandom_range(0, 3));
            tick(1);
        end

        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.pause = 1'b0; bus.dir = 1'b0;
        tick(10);
        repeat (3) press(1'b1, 1'b0, 6);
        repeat (2) press(1'b0, 1'b1, 6);
        check("speed_two", 32'(bus.speed), 32'd2);
        tick(5);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_disp",  32'(bus.disp),  32'(7'b0111111));
        check("midrst_anode", 32'(bus.anode), 32'(4'b1110));
        check("midrst_speed", 32'(bus.speed), 32'd0);
        bus.dsel = 2'd0;
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        bus.dsel = 2'd3;
        tick(1);
        check("dsel3_anode", 32'(bus.anode), 32'(4'b0111));
        tick(40);
        check("queue_drain", 32'(sq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
